fifo_lector_uart: RTL and testbench
===================================

// Module: fifo_lector_uart
// PURPOSE
//  Read side of the ADC sample FIFO (16x1024). Drains 16-bit samples from the
//  FIFO read port and sends each one over an 8N1 UART line, MSB byte first.
//  Sits between the FIFO (rd_en/dato/empty) and the board TX pin on the
//  100 MHz domain.
// PARAMETERS
//  CLKS_POR_BIT  868  clock cycles per UART bit (100 MHz / 115200 baud)
//  DATA_W        16   FIFO word width; multiple of 8; NUM_BYTES = DATA_W/8
//  CUENTA_W      16   width of the transmitted-word counter
// PORTS
//  clk_100MHz_i  in   1         system clock, 100 MHz
//  rst_i         in   1         asynchronous reset, active-high
//  habilitar_i   in   1         level; 1 = allowed to start draining words
//  empty_i       in   1         FIFO empty flag
//  dato_i        in   DATA_W    FIFO read data; valid 1 cycle after rd_en_o
//  rd_en_o       out  1         FIFO read strobe; single-cycle pulse
//  tx_o          out  1         UART serial output; idle high
//  ocupado_o     out  1         1 whenever state != REPOSO
//  cuenta_o      out  CUENTA_W  number of words fully transmitted
// BEHAVIOUR
//  Reset (async, immediate): rd_en_o=0, tx_o=1, ocupado_o=0, cuenta_o=0,
//   state=REPOSO, bit/baud/byte counters cleared. All outputs registered.
//  FSM states: REPOSO, LEER, CAPTURA, INICIO, BITS, PARADA.
//  - REPOSO: if habilitar_i && !empty_i at the clock edge -> LEER, else stay.
//  - LEER: rd_en_o=1 for exactly this one cycle -> CAPTURA.
//  - CAPTURA: latch dato_i into word buffer; byte_idx=NUM_BYTES-1 -> INICIO.
//  - INICIO: tx_o=0 for CLKS_POR_BIT cycles -> BITS.
//  - BITS: byte[byte_idx] shifted out LSB first, 8 bits, each held
//    CLKS_POR_BIT cycles -> PARADA.
//  - PARADA: tx_o=1 for CLKS_POR_BIT cycles; if byte_idx!=0: byte_idx-1,
//    -> INICIO; else cuenta_o+1 (same edge as leaving PARADA) -> REPOSO.
//  Timing: start bit begins 2 cycles after rd_en_o pulse; one word frame =
//   NUM_BYTES*10*CLKS_POR_BIT cycles; min 1 REPOSO cycle between words.
//  rd_en_o is never asserted when empty_i=1 in the deciding cycle, and never
//   more than once per word.
//  empty_i and habilitar_i are ignored outside REPOSO: dropping habilitar_i
//   mid-word finishes the current word, then no further reads.
//  cuenta_o wraps 2^CUENTA_W-1 -> 0.
//  Reset mid-frame: tx_o returns high immediately, partial word discarded
//   (not counted); after release restart only via REPOSO with a fresh read.
//  No rd_en_o pulse while rst_i=1.
// TESTING  (bench uses CLKS_POR_BIT=4, DATA_W=16; FIFO model with 1-cycle read)
//  1 rst_i=1 for 20 cycles -> tx_o=1, rd_en_o=0, ocupado_o=0, cuenta_o=0.
//  2 one word 0xA55A, habilitar_i=1 -> one rd_en_o pulse; line bits
//    0,1010 0101,1 then 0,0101 1010,1 (0xA5 then 0x5A, LSB first); 80-cycle
//    frame; cuenta_o=1; ocupado_o back to 0.
//  3 empty_i=1, habilitar_i=1 for 1000 cycles -> rd_en_o never 1, tx_o=1.
//  4 FIFO holds 0x0001,0x8000,0xFFFF -> exactly 3 rd_en_o pulses, bytes
//    00 01 80 00 FF FF on tx_o, cuenta_o=3, no pulse after empty_i rises.
//  5 habilitar_i->0 during 2nd data bit of first byte -> both bytes of word
//    still sent, cuenta_o+1, no further rd_en_o though FIFO not empty.
//  6 rst_i pulse during BITS -> tx_o=1 same cycle, cuenta_o=0; after release
//    next word begins with new rd_en_o pulse and full start bit.

Source files
------------

// File: rtl/fifo_lector_uart.sv
// Drains words from the ADC sample FIFO and ships each one out as 8N1 UART bytes,
// most significant byte first, least significant bit of each byte first.
module fifo_lector_uart #(
  parameter int CLKS_POR_BIT = 868,
  parameter int DATA_W       = 16,
  parameter int CUENTA_W     = 16
) (
  input  logic                clk_100MHz_i,
  input  logic                rst_i,
  input  logic                habilitar_i,
  input  logic                empty_i,
  input  logic [DATA_W-1:0]   dato_i,
  output logic                rd_en_o,
  output logic                tx_o,
  output logic                ocupado_o,
  output logic [CUENTA_W-1:0] cuenta_o
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int BAUD_W    = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_POR_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {REPOSO, LEER, CAPTURA, INICIO, BITS, PARADA} estado_t;

  estado_t             estado;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [DATA_W-1:0]   palabra;
  logic [7:0]          byte_sh;
  logic                baud_fin;

  assign baud_fin = (baud_cnt == BAUD_MAX);

  // Control path: state, line level, strobes and counters
  always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      estado    <= REPOSO;
      rd_en_o   <= 1'b0;
      tx_o      <= 1'b1;
      ocupado_o <= 1'b0;
      cuenta_o  <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
    end else begin
      rd_en_o <= 1'b0;
      case (estado)
        REPOSO: begin
          baud_cnt <= '0;
          if (habilitar_i && !empty_i) begin
            estado    <= LEER;
            rd_en_o   <= 1'b1;
            ocupado_o <= 1'b1;
          end
        end
        LEER: estado <= CAPTURA;
        CAPTURA: begin
          byte_idx <= BYTE_MAX;
          baud_cnt <= '0;
          tx_o     <= 1'b0;
          estado   <= INICIO;
        end
        INICIO: begin
          if (baud_fin) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_o     <= palabra[DATA_W-8];
            estado   <= BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BITS: begin
          if (baud_fin) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_o   <= 1'b1;
              estado <= PARADA;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= byte_sh[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARADA: begin
          if (baud_fin) begin
            baud_cnt <= '0;
            if (byte_idx != '0) begin
              byte_idx <= byte_idx - 1'b1;
              tx_o     <= 1'b0;
              estado   <= INICIO;
            end else begin
              cuenta_o  <= cuenta_o + 1'b1;
              ocupado_o <= 1'b0;
              estado    <= REPOSO;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

  // Data path: the word buffer keeps the byte in flight in its top 8 bits
  always_ff @(posedge clk_100MHz_i) begin
    if (estado == CAPTURA)
      palabra <= dato_i;
    else if (estado == PARADA && baud_fin && byte_idx != '0)
      palabra <= palabra << 8;

    if (estado == INICIO && baud_fin)
      byte_sh <= palabra[DATA_W-1 -: 8] >> 1;
    else if (estado == BITS && baud_fin)
      byte_sh <= byte_sh >> 1;
  end

endmodule

// File: tb/tb_fifo_lector_uart.sv
// Directed bench for fifo_lector_uart: FIFO model with 1-cycle read latency and a
// bit-accurate UART line sampler at CLKS_POR_BIT=4.
module tb_fifo_lector_uart;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        habilitar_i;
  logic        empty_i;
  logic [15:0] dato_i;
  logic        rd_en_o;
  logic        tx_o;
  logic        ocupado_o;
  logic [15:0] cuenta_o;

  fifo_lector_uart #(.CLKS_POR_BIT(4), .DATA_W(16), .CUENTA_W(16)) dut (
    .clk_100MHz_i(clk),
    .rst_i       (rst_i),
    .habilitar_i (habilitar_i),
    .empty_i     (empty_i),
    .dato_i      (dato_i),
    .rd_en_o     (rd_en_o),
    .tx_o        (tx_o),
    .ocupado_o   (ocupado_o),
    .cuenta_o    (cuenta_o)
  );

  always #5 clk = ~clk;

  // FIFO model: writes from the stimulus process, reads on rd_en_o
  logic [15:0] fifo_mem [0:63];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  assign empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en_o && !empty_i) begin
      dato_i <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  int cyc = 0;
  int pulses = 0;
  int viol = 0;
  int pulses_in_rst = 0;
  int tx_low_cnt = 0;
  logic emp_dec = 1'b1;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    emp_dec <= empty_i;
  end

  always @(negedge clk) begin
    if (rd_en_o === 1'b1) pulses++;
    if (rd_en_o === 1'b1 && emp_dec) viol++;
    if (rd_en_o === 1'b1 && rst_i) pulses_in_rst++;
    if (tx_o === 1'b0) tx_low_cnt++;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Entered on a falling edge; returns on the falling edge right after the stop bit
  task automatic rx_byte(output logic [7:0] b, output int t0, input bit drop_hab);
    int guard;
    guard = 0;
    b = 'x;
    while (tx_o !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    t0 = cyc;
    if (guard >= 200) begin
      check("rx_start_timeout", {31'd0, tx_o}, 32'd0);
      return;
    end
    repeat (2) @(negedge clk);
    check("start_bit_mid", {31'd0, tx_o}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx_o;
      if (drop_hab && i == 1) habilitar_i = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("stop_bit_mid", {31'd0, tx_o}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_word(output logic [15:0] w, input bit drop_hab);
    int guard, r, t0, t1;
    logic [7:0] hi, lo;
    guard = 0;
    while (rd_en_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rd_en_seen", {31'd0, rd_en_o}, 32'd1);
    r = cyc;
    rx_byte(hi, t0, drop_hab);
    rx_byte(lo, t1, 1'b0);
    check("start_latency", t0 - r, 32'd2);
    check("byte_spacing", t1 - t0, 32'd40);
    check("ocupado_after_word", {31'd0, ocupado_o}, 32'd0);
    w = {hi, lo};
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b_hi;
    logic [7:0]  b_lo;
  } vec_t;

  vec_t vecs [5];
  vec_t burst [3];

  initial begin
    logic [15:0] w;
    int p0, c0, l0;

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h1234, 8'h12, 8'h34};
    vecs[2] = '{16'h00FF, 8'h00, 8'hFF};
    vecs[3] = '{16'h8001, 8'h80, 8'h01};
    vecs[4] = '{16'h6BD2, 8'h6B, 8'hD2};
    burst[0] = '{16'h0001, 8'h00, 8'h01};
    burst[1] = '{16'h8000, 8'h80, 8'h00};
    burst[2] = '{16'hFFFF, 8'hFF, 8'hFF};

    rst_i = 1'b1;
    habilitar_i = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
    check("rst_ocupado", {31'd0, ocupado_o}, 32'd0);
    check("rst_cuenta", {16'd0, cuenta_o}, 32'd0);
    rst_i = 1'b0;

    // Enabled but empty: no reads, line idle
    habilitar_i = 1'b1;
    p0 = pulses;
    l0 = tx_low_cnt;
    repeat (1000) @(negedge clk);
    check("empty_no_rd", pulses - p0, 32'd0);
    check("empty_tx_idle", tx_low_cnt - l0, 32'd0);

    // One word at a time from the vector table
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      push(vecs[i].word);
      rd_word(w, 1'b0);
      check($sformatf("vec%0d_hi", i), {24'd0, w[15:8]}, {24'd0, vecs[i].b_hi});
      check($sformatf("vec%0d_lo", i), {24'd0, w[7:0]}, {24'd0, vecs[i].b_lo});
      check($sformatf("vec%0d_cuenta", i), {16'd0, cuenta_o}, i + 1);
      check($sformatf("vec%0d_pulses", i), pulses - p0, 32'd1);
    end

    // Back-to-back words already queued
    p0 = pulses;
    for (int i = 0; i < 3; i++) push(burst[i].word);
    for (int i = 0; i < 3; i++) begin
      rd_word(w, 1'b0);
      check($sformatf("burst%0d_word", i), {16'd0, w}, {16'd0, burst[i].b_hi, burst[i].b_lo});
    end
    repeat (100) @(negedge clk);
    check("burst_pulses", pulses - p0, 32'd3);
    check("burst_cuenta", {16'd0, cuenta_o}, 32'd8);

    // Enable drops mid-word: word completes, next word stays in the FIFO
    p0 = pulses;
    push(16'h3C96);
    push(16'h7E81);
    rd_word(w, 1'b1);
    check("drop_word", {16'd0, w}, 32'h3C96);
    check("drop_cuenta", {16'd0, cuenta_o}, 32'd9);
    repeat (200) @(negedge clk);
    check("drop_pulses", pulses - p0, 32'd1);
    check("drop_fifo_left", {31'd0, empty_i}, 32'd0);
    check("drop_tx_idle", {31'd0, tx_o}, 32'd1);

    // Reset during the data bits of 0x7E (bit0 = 0)
    habilitar_i = 1'b1;
    c0 = 0;
    while (tx_o !== 1'b0 && c0 < 100) begin
      @(negedge clk);
      c0++;
    end
    repeat (5) @(negedge clk);
    check("pre_rst_tx_low", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check("midrst_tx", {31'd0, tx_o}, 32'd1);
    check("midrst_cuenta", {16'd0, cuenta_o}, 32'd0);
    check("midrst_ocupado", {31'd0, ocupado_o}, 32'd0);
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    p0 = pulses;
    push(16'hC33C);
    rd_word(w, 1'b0);
    check("post_rst_word", {16'd0, w}, 32'hC33C);
    check("post_rst_cuenta", {16'd0, cuenta_o}, 32'd1);
    check("post_rst_pulses", pulses - p0, 32'd1);

    check("rd_en_while_empty", viol, 32'd0);
    check("rd_en_during_rst", pulses_in_rst, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
